// File: rtl/pri_arbiter.sv
// Registered N-way priority arbiter with fixed or round-robin ordering and an
// optional hold timeout that hands the resource to another pending requester.
module pri_arbiter #(
    parameter int N        = 8,
    parameter int RR_MODE  = 0,
    parameter int MAX_HOLD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 gnt_vld,
    output logic                 idle
);

    localparam int IW = $clog2(N);
    localparam logic [7:0] HOLD_LAST = 8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t          state_reg;
    logic [IW-1:0]   last_reg;
    logic [7:0]      hold_cnt_reg;

    logic [N-1:0]    cand;
    logic [2*N-1:0]  dbl;
    logic [2*N-1:0]  dbl_mask;
    logic [IW-1:0]   start;
    logic [IW-1:0]   win_idx;
    logic            win_any;
    logic [N-1:0]    win_onehot;
    logic            owner_req;
    logic            timeout;

    // The current owner is never a candidate; in IDLE gnt is zero so all requests count.
    assign cand  = req & ~gnt;
    assign start = (RR_MODE != 0) ? last_reg : '0;
    assign dbl   = {cand, cand};

    // Keep only positions below N+start in the doubled vector: the highest surviving
    // bit is then the first requester in the order start-1, ..., 0, N-1, ..., start.
    generate
        for (genvar gi = 0; gi < 2*N; gi++) begin : g_mask
            assign dbl_mask[gi] = (gi < N + int'(start));
        end
    endgenerate

    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        for (int p = 0; p < 2*N; p++) begin
            if (dbl[p] && dbl_mask[p]) begin
                win_any = 1'b1;
                win_idx = (p >= N) ? IW'(p - N) : IW'(p);
            end
        end
    end

    assign win_onehot = N'(1) << win_idx;
    assign owner_req  = |(req & gnt);
    assign timeout    = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            gnt          <= '0;
            gnt_id       <= '0;
            gnt_vld      <= 1'b0;
            idle         <= 1'b1;
            last_reg     <= '0;
            hold_cnt_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (win_any) begin
                        state_reg    <= S_GRANT;
                        gnt          <= win_onehot;
                        gnt_id       <= win_idx;
                        gnt_vld      <= 1'b1;
                        idle         <= 1'b0;
                        last_reg     <= win_idx;
                        hold_cnt_reg <= '0;
                    end
                end
                S_GRANT: begin
                    if (!owner_req || timeout) begin
                        if (win_any) begin
                            gnt          <= win_onehot;
                            gnt_id       <= win_idx;
                            last_reg     <= win_idx;
                            hold_cnt_reg <= '0;
                        end else if (!owner_req) begin
                            state_reg    <= S_IDLE;
                            gnt          <= '0;
                            gnt_id       <= '0;
                            gnt_vld      <= 1'b0;
                            idle         <= 1'b1;
                            hold_cnt_reg <= '0;
                        end
                        // Timed out with nobody waiting: keep the grant, counter stays saturated.
                    end else if (MAX_HOLD != 0 && hold_cnt_reg != HOLD_LAST) begin
                        hold_cnt_reg <= hold_cnt_reg + 8'd1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pri_arbiter.sv
// Bench for pri_arbiter: four configurations checked every cycle against a
// list-based priority model, plus directed scenarios with literal expectations.
module tb_pri_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_a, req_c, req_d;
    logic [3:0] req_b;
    logic [7:0] gnt_a, gnt_c, gnt_d;
    logic [3:0] gnt_b;
    logic [2:0] id_a, id_c, id_d;
    logic [1:0] id_b;
    logic       vld_a, vld_b, vld_c, vld_d;
    logic       idle_a, idle_b, idle_c, idle_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pri_arbiter #(.N(8), .RR_MODE(0), .MAX_HOLD(0)) u_a (
        .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .gnt_id(id_a), .gnt_vld(vld_a), .idle(idle_a));
    pri_arbiter #(.N(4), .RR_MODE(1), .MAX_HOLD(0)) u_b (
        .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_id(id_b), .gnt_vld(vld_b), .idle(idle_b));
    pri_arbiter #(.N(8), .RR_MODE(0), .MAX_HOLD(4)) u_c (
        .clk(clk), .rst(rst), .req(req_c), .gnt(gnt_c), .gnt_id(id_c), .gnt_vld(vld_c), .idle(idle_c));
    pri_arbiter #(.N(8), .RR_MODE(1), .MAX_HOLD(2)) u_d (
        .clk(clk), .rst(rst), .req(req_d), .gnt(gnt_d), .gnt_id(id_d), .gnt_vld(vld_d), .idle(idle_d));

    // ---------------- behavioural model ----------------
    localparam int NN  [4] = '{8, 4, 8, 8};
    localparam int RRV [4] = '{0, 1, 0, 1};
    localparam int MHV [4] = '{0, 0, 4, 2};

    int m_owner [4];
    int m_last  [4];
    int m_held  [4];

    // Priority list: index just below the previous owner first, previous owner last.
    function automatic int pick(int n, int rr, int last, logic [7:0] r, int excl);
        int order[$];
        int s;
        s = (rr != 0) ? last : 0;
        for (int j = 1; j <= n; j++) order.push_back((s - j + n) % n);
        foreach (order[q]) begin
            if (r[order[q]] && order[q] != excl) return order[q];
        end
        return -1;
    endfunction

    function automatic logic [7:0] get_req(int i);
        case (i)
            0: return req_a;
            1: return {4'h0, req_b};
            2: return req_c;
            default: return req_d;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_owner[i] = -1; m_last[i] = 0; m_held[i] = 0;
        end
    end

    always @(posedge clk) begin
        logic [7:0] r;
        logic [7:0] g, eg;
        int id, w;
        logic v, idl;
        for (int i = 0; i < 4; i++) begin
            r = get_req(i);
            if (rst) begin
                m_owner[i] = -1; m_last[i] = 0; m_held[i] = 0;
            end else if (m_owner[i] < 0) begin
                w = pick(NN[i], RRV[i], m_last[i], r, -1);
                if (w >= 0) begin m_owner[i] = w; m_last[i] = w; m_held[i] = 1; end
            end else if (!r[m_owner[i]] || (MHV[i] != 0 && m_held[i] >= MHV[i])) begin
                w = pick(NN[i], RRV[i], m_last[i], r, m_owner[i]);
                if (w >= 0) begin m_owner[i] = w; m_last[i] = w; m_held[i] = 1; end
                else if (!r[m_owner[i]]) m_owner[i] = -1;
            end else begin
                m_held[i] = m_held[i] + 1;
            end
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin g = gnt_a; id = int'(id_a); v = vld_a; idl = idle_a; end
                1: begin g = {4'h0, gnt_b}; id = int'(id_b); v = vld_b; idl = idle_b; end
                2: begin g = gnt_c; id = int'(id_c); v = vld_c; idl = idle_c; end
                default: begin g = gnt_d; id = int'(id_d); v = vld_d; idl = idle_d; end
            endcase
            eg = (m_owner[i] < 0) ? 8'h00 : (8'h01 << m_owner[i]);
            checks++;
            if (g !== eg || id != ((m_owner[i] < 0) ? 0 : m_owner[i]) || v !== (m_owner[i] >= 0)
                || idl !== (m_owner[i] < 0) || $countones(g) > 1) begin
                errors++;
                $display("FAIL model inst%0d t=%0t: gnt=%h id=%0d vld=%b idle=%b, expected gnt=%h id=%0d",
                         i, $time, g, id, v, idl, eg, (m_owner[i] < 0) ? 0 : m_owner[i]);
            end
        end
    end

    // ---------------- directed checks ----------------
    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [7:0] tmp;
        int exp_seq [4] = '{2, 1, 0, 3};
        rst = 1'b1;
        req_a = 8'h00; req_b = 4'h0; req_c = 8'h00; req_d = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk("reset_gnt", int'(gnt_a), 0);
        chk("reset_idle", int'(idle_a), 1);

        // async reset in the middle of a grant
        @(negedge clk) req_a = 8'h10;
        after_edge();
        chk("pre_reset_gnt", int'(gnt_a), 'h10);
        @(negedge clk) begin rst = 1'b1; req_a = 8'h00; end
        #1;
        chk("async_rst_gnt", int'(gnt_a), 0);
        chk("async_rst_id", int'(id_a), 0);
        chk("async_rst_idle", int'(idle_a), 1);
        chk("async_rst_vld", int'(vld_a), 0);
        @(negedge clk) rst = 1'b0;

        // fixed priority and direct handoff
        @(negedge clk) req_a = 8'hA4;
        after_edge();
        chk("fixed_a4_gnt", int'(gnt_a), 'h80);
        chk("fixed_a4_id", int'(id_a), 7);
        @(negedge clk) req_a = 8'h24;
        after_edge();
        chk("handoff_gnt", int'(gnt_a), 'h20);
        chk("handoff_idle", int'(idle_a), 0);
        @(negedge clk) req_a = 8'h01;
        after_edge();
        chk("low_gnt", int'(gnt_a), 'h01);
        @(negedge clk) req_a = 8'h00;
        after_edge();
        chk("release_gnt", int'(gnt_a), 0);
        chk("release_idle", int'(idle_a), 1);

        // round robin rotation
        @(negedge clk) req_b = 4'hF;
        after_edge();
        chk("rr_first", int'(id_b), 3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk) req_b = 4'hF & ~gnt_b;
            after_edge();
            chk($sformatf("rr_step%0d", k), int'(id_b), exp_seq[k]);
            @(negedge clk) req_b = 4'hF;
            after_edge();
            chk($sformatf("rr_hold%0d", k), int'(id_b), exp_seq[k]);
        end
        @(negedge clk) req_b = 4'h0;

        // timeout alternation
        @(negedge clk) req_c = 8'h03;
        for (int c = 0; c < 16; c++) begin
            after_edge();
            chk($sformatf("timeout_c%0d", c), int'(gnt_c), ((c / 4) % 2 == 0) ? 'h02 : 'h01);
        end
        @(negedge clk) req_c = 8'h00;

        // lone requester under timeout keeps the grant
        @(negedge clk) req_d = 8'h40;
        for (int c = 0; c < 8; c++) begin
            after_edge();
            chk($sformatf("lone_gnt%0d", c), int'(gnt_d), 'h40);
            chk($sformatf("lone_idle%0d", c), int'(idle_d), 0);
        end
        @(negedge clk) req_d = 8'h00;

        // random regression, with glitches and one asynchronous reset
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) req_a = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 2) == 0) req_b = 4'($urandom);
            if ($urandom_range(0, 3) == 0) req_c = 8'($urandom);
            if ($urandom_range(0, 3) == 0) req_d = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                tmp = req_a;
                #1 req_a = 8'($urandom);
                #2 req_a = tmp;
            end
            if (c == 1500) begin
                #3 rst = 1'b1;
                @(negedge clk) rst = 1'b0;
            end
        end
        @(negedge clk) begin req_a = 0; req_b = 0; req_c = 0; req_d = 0; end
        repeat (3) @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
